// File: rtl/alu_pkg.sv
// Shared ALU definitions: alu_control opcodes and requester identifiers.
package alu_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLTU = 4'b1010;
  localparam logic [3:0] ALU_SLT  = 4'b1011;
  localparam logic [3:0] ALU_XOR  = 4'b1111;

  typedef enum logic {
    REQ_S = 1'b0,
    REQ_V = 1'b1
  } req_id_e;

endpackage

// File: rtl/alu_arb_pick.sv
// Winner select between scalar and vector requesters, plus the vector starvation counter.
module alu_arb_pick
  import alu_pkg::*;
#(
  parameter int unsigned PRIO_SCALAR = 1,
  parameter int unsigned STARVE_MAX  = 8
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    flush,
  input  logic    s_valid,
  input  logic    v_valid,
  input  logic    issue,
  input  req_id_e last_grant,
  output req_id_e winner,
  output logic    conflict
);

  localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

  logic [CNT_W-1:0] starve_cnt;
  logic             starved;

  assign conflict = s_valid & v_valid;
  assign starved  = (starve_cnt == CNT_W'(STARVE_MAX));

  always_comb begin
    winner = REQ_S;
    if (conflict) begin
      if (PRIO_SCALAR != 0) winner = starved ? REQ_V : REQ_S;
      else                  winner = (last_grant == REQ_S) ? REQ_V : REQ_S;
    end else if (v_valid) begin
      winner = REQ_V;
    end
  end

  // Counts consecutive conflict cycles that V actually lost to S.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      starve_cnt <= '0;
    end else if (!v_valid || (issue && winner == REQ_V)) begin
      starve_cnt <= '0;
    end else if (conflict && issue && winner == REQ_S && !starved) begin
      starve_cnt <= starve_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/alu_share_arb.sv
// Shares one scalar ALU between the scalar EX stage and the vector unit with a single result slot.
// Optional ALU_SHARE_ARB_PERF_EN adds grant/conflict/stall performance counters.
module alu_share_arb
  import alu_pkg::*;
#(
  parameter int unsigned XLEN        = 64,
  parameter int unsigned TAGW        = 5,
  parameter int unsigned PRIO_SCALAR = 1,
  parameter int unsigned STARVE_MAX  = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            s_req_valid,
  output logic            s_req_ready,
  input  logic [3:0]      s_req_op,
  input  logic [XLEN-1:0] s_req_a,
  input  logic [XLEN-1:0] s_req_b,
  input  logic [TAGW-1:0] s_req_tag,
  input  logic            v_req_valid,
  output logic            v_req_ready,
  input  logic [3:0]      v_req_op,
  input  logic [XLEN-1:0] v_req_a,
  input  logic [XLEN-1:0] v_req_b,
  input  logic [TAGW-1:0] v_req_tag,
  output logic            s_rsp_valid,
  input  logic            s_rsp_ready,
  output logic [XLEN-1:0] s_rsp_data,
  output logic [TAGW-1:0] s_rsp_tag,
  output logic            v_rsp_valid,
  input  logic            v_rsp_ready,
  output logic [XLEN-1:0] v_rsp_data,
  output logic [TAGW-1:0] v_rsp_tag,
  output logic [3:0]      alu_control,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  input  logic [XLEN-1:0] alu_result
`ifdef ALU_SHARE_ARB_PERF_EN
  ,
  output logic [31:0]     perf_s_grants,
  output logic [31:0]     perf_v_grants,
  output logic [31:0]     perf_conflicts,
  output logic [31:0]     perf_stalls
`endif
);

  logic            res_valid;
  req_id_e         owner;
  req_id_e         last_grant;
  req_id_e         winner;
  logic [XLEN-1:0] res_data;
  logic [TAGW-1:0] res_tag;
  logic            any_valid;
  logic            conflict;
  logic            owner_ready;
  logic            slot_free;
  logic            issue;

  assign any_valid   = s_req_valid | v_req_valid;
  assign owner_ready = (owner == REQ_S) ? s_rsp_ready : v_rsp_ready;
  assign slot_free   = !res_valid || owner_ready;
  assign issue       = rst_n && slot_free && !flush && any_valid;

  alu_arb_pick #(
    .PRIO_SCALAR (PRIO_SCALAR),
    .STARVE_MAX  (STARVE_MAX)
  ) u_pick (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .s_valid    (s_req_valid),
    .v_valid    (v_req_valid),
    .issue      (issue),
    .last_grant (last_grant),
    .winner     (winner),
    .conflict   (conflict)
  );

  // Request handshake and ALU operand steering for the current winner.
  always_comb begin
    s_req_ready = 1'b0;
    v_req_ready = 1'b0;
    alu_control = 4'b0000;
    alu_a       = '0;
    alu_b       = '0;
    if (issue) begin
      if (winner == REQ_S) begin
        s_req_ready = 1'b1;
        alu_control = s_req_op;
        alu_a       = s_req_a;
        alu_b       = s_req_b;
      end else begin
        v_req_ready = 1'b1;
        alu_control = v_req_op;
        alu_a       = v_req_a;
        alu_b       = v_req_b;
      end
    end
  end

  // Result slot: a new issue overwrites a draining result without a bubble.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_valid  <= 1'b0;
      owner      <= REQ_S;
      last_grant <= REQ_V;
      res_data   <= '0;
      res_tag    <= '0;
    end else if (flush) begin
      res_valid <= 1'b0;
    end else if (issue) begin
      res_valid  <= 1'b1;
      owner      <= winner;
      last_grant <= winner;
      res_data   <= alu_result;
      res_tag    <= (winner == REQ_S) ? s_req_tag : v_req_tag;
    end else if (res_valid && owner_ready) begin
      res_valid <= 1'b0;
    end
  end

  assign s_rsp_valid = res_valid && (owner == REQ_S);
  assign v_rsp_valid = res_valid && (owner == REQ_V);
  assign s_rsp_data  = res_data;
  assign v_rsp_data  = res_data;
  assign s_rsp_tag   = res_tag;
  assign v_rsp_tag   = res_tag;

`ifdef ALU_SHARE_ARB_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_s_grants  <= '0;
      perf_v_grants  <= '0;
      perf_conflicts <= '0;
      perf_stalls    <= '0;
    end else begin
      if (issue && winner == REQ_S) perf_s_grants <= perf_s_grants + 32'd1;
      if (issue && winner == REQ_V) perf_v_grants <= perf_v_grants + 32'd1;
      if (issue && conflict)        perf_conflicts <= perf_conflicts + 32'd1;
      if (any_valid && !slot_free)  perf_stalls <= perf_stalls + 32'd1;
    end
  end
`endif

endmodule
